// File: rtl/access_attempt_ctrl.sv
// Keypad lock attempt sequencer: owns the checker strobe and enforces entry/response
// timeouts, the timed unlock window and the lockout after MAX_FAIL consecutive failures.
//
// state     | meaning
// IDLE      | waiting for the first digit of an attempt
// ENTRY     | collecting digits, inactivity timer running
// CHECK     | one-cycle compare strobe to the checker
// WAIT_RES  | waiting for pass/fail, response timer running
// OPEN      | door unlocked for UNLOCK_CYCLES
// LOCKOUT   | buzzer and key lockout for LOCK_CYCLES
module access_attempt_ctrl #(
    parameter int MAX_FAIL      = 3,
    parameter int UNLOCK_CYCLES = 500,
    parameter int LOCK_CYCLES   = 1000,
    parameter int ENTRY_TIMEOUT = 2000,
    parameter int RESP_TIMEOUT  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic                              attempt_done,
    input  logic                              chk_pass,
    input  logic                              chk_fail,
    output logic                              key_accept,
    output logic                              check,
    output logic                              door_open,
    output logic                              buzzer,
    output logic                              locked_out,
    output logic                              busy,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

    localparam int MAX_A = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int MAX_B = (ENTRY_TIMEOUT > RESP_TIMEOUT) ? ENTRY_TIMEOUT : RESP_TIMEOUT;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_T) + 1;
    localparam int FW    = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_OPEN     = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic [FW-1:0]   fail_nxt;
    logic [FW-1:0]   fail_inc;

    assign key_accept = key_valid && ((state == S_IDLE) || (state == S_ENTRY));
    assign fail_inc   = fail_count + FW'(1);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + TW'(1);
        fail_nxt  = fail_count;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (key_valid) state_nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (attempt_done)
                    state_nxt = S_CHECK;
                else if (key_valid)
                    timer_nxt = '0;
                else if (timer == TW'(ENTRY_TIMEOUT - 1))
                    state_nxt = S_IDLE;
            end
            S_CHECK: state_nxt = S_WAIT_RES;
            S_WAIT_RES: begin
                // a simultaneous pass+fail is resolved as a failure
                if (chk_fail || (!chk_pass && (timer == TW'(RESP_TIMEOUT - 1)))) begin
                    fail_nxt  = fail_inc;
                    state_nxt = (fail_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
                end else if (chk_pass) begin
                    fail_nxt  = '0;
                    state_nxt = S_OPEN;
                end
            end
            S_OPEN: begin
                if (timer == TW'(UNLOCK_CYCLES - 1)) state_nxt = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer == TW'(LOCK_CYCLES - 1)) begin
                    fail_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt != state) timer_nxt = '0;
    end

    // outputs decode the next state so they are valid in the first cycle of that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            fail_count <= '0;
            check      <= 1'b0;
            door_open  <= 1'b0;
            buzzer     <= 1'b0;
            locked_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            fail_count <= fail_nxt;
            check      <= (state_nxt == S_CHECK);
            door_open  <= (state_nxt == S_OPEN);
            buzzer     <= (state_nxt == S_LOCKOUT);
            locked_out <= (state_nxt == S_LOCKOUT);
            busy       <= (state_nxt == S_CHECK) || (state_nxt == S_WAIT_RES);
        end
    end

endmodule

// File: tb/tb_access_attempt_ctrl.sv
// Scoreboard bench for access_attempt_ctrl: stimulus queues expected output events,
// a monitor reconstructs check pulses, fail_count changes and open/lockout windows.
module tb_access_attempt_ctrl;

    localparam int MAX_FAIL = 3;
    localparam int UNLOCK   = 10;
    localparam int LOCK     = 20;
    localparam int ETO      = 30;
    localparam int RTO      = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic       attempt_done = 1'b0;
    logic       chk_pass = 1'b0;
    logic       chk_fail = 1'b0;
    logic       key_accept, check, door_open, buzzer, locked_out, busy;
    logic [1:0] fail_count;

    access_attempt_ctrl #(
        .MAX_FAIL(MAX_FAIL), .UNLOCK_CYCLES(UNLOCK), .LOCK_CYCLES(LOCK),
        .ENTRY_TIMEOUT(ETO), .RESP_TIMEOUT(RTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .attempt_done(attempt_done),
        .chk_pass(chk_pass), .chk_fail(chk_fail), .key_accept(key_accept), .check(check),
        .door_open(door_open), .buzzer(buzzer), .locked_out(locked_out), .busy(busy),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_CHECK, EV_FCNT, EV_OPEN, EV_LOCK} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       value;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  m_fail = 0;
    bit  done = 1'b0;
    bit  mon_en = 1'b0;

    task automatic expect_ev(input ev_kind_t k, input int v);
        ev_t e;
        e.kind  = k;
        e.value = v;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic observe(input ev_kind_t k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s=%0d, want none (t=%0t)", k.name(), v, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.value != v) begin
                errors++;
                $display("FAIL event: got %s=%0d, want %s=%0d (t=%0t)",
                         k.name(), v, e.kind.name(), e.value, $time);
            end
        end
    endtask

    task automatic monitor();
        int         chk_w = 0;
        int         open_w = 0;
        int         lock_w = 0;
        logic [1:0] prev_f = 2'd0;
        while (!done) begin
            @(negedge clk);
            if (mon_en) begin
                if (check) chk_w++;
                else if (chk_w > 0) begin observe(EV_CHECK, chk_w); chk_w = 0; end
                if (fail_count != prev_f) observe(EV_FCNT, int'(fail_count));
                if (door_open) open_w++;
                else if (open_w > 0) begin observe(EV_OPEN, open_w); open_w = 0; end
                if (buzzer != locked_out) cmp("buzzer_vs_locked_out", buzzer, locked_out);
                if (buzzer && locked_out) lock_w++;
                else if (lock_w > 0) begin observe(EV_LOCK, lock_w); lock_w = 0; end
            end
            prev_f = fail_count;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic key(input bit acc);
        @(posedge clk); #1 key_valid = 1'b1;
        #1 cmp("key_accept", key_accept, acc);
        @(posedge clk); #1 key_valid = 1'b0;
    endtask

    task automatic submit(input bit exp_chk);
        @(posedge clk); #1 attempt_done = 1'b1;
        if (exp_chk) expect_ev(EV_CHECK, 1);
        @(posedge clk); #1 attempt_done = 1'b0;
    endtask

    task automatic attempt(input int nkeys);
        repeat (nkeys) key(1'b1);
        submit(1'b1);
    endtask

    // full=1 queues the complete open/lockout window; 0 leaves that to the caller
    task automatic result(input int dly, input bit p, input bit f, input bit full);
        tick(dly);
        #1 cmp("busy_wait_res", busy, 1);
        chk_pass = p;
        chk_fail = f;
        if (f) begin
            m_fail++;
            expect_ev(EV_FCNT, m_fail);
            if (m_fail == MAX_FAIL && full) begin
                expect_ev(EV_FCNT, 0);
                expect_ev(EV_LOCK, LOCK);
                m_fail = 0;
            end
        end else begin
            if (m_fail != 0) expect_ev(EV_FCNT, 0);
            m_fail = 0;
            if (full) expect_ev(EV_OPEN, UNLOCK);
        end
        @(posedge clk); #1 chk_pass = 1'b0; chk_fail = 1'b0;
    endtask

    task automatic wait_high(input bit sel_lock, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = sel_lock ? locked_out : door_open;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout, want assertion within 100 cycles", name);
        end
    endtask

    task automatic stimulus();
        #1 rst_n = 1'b0;
        #1 key_valid = 1'b1;
        #1 cmp("rst_key_accept_gate", key_accept, 1);
        key_valid = 1'b0;
        #1;
        cmp("rst_key_accept", key_accept, 0);
        cmp("rst_door_open", door_open, 0);
        cmp("rst_buzzer", buzzer, 0);
        cmp("rst_locked_out", locked_out, 0);
        cmp("rst_check", check, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_fail_count", fail_count, 0);
        mon_en = 1'b1;
        tick(2); #1 rst_n = 1'b1;

        // good attempt, inputs ignored while open
        attempt(4);
        result(2, 1'b1, 1'b0, 1'b1);
        cmp("pass_fail_count", fail_count, 0);
        key(1'b0);
        submit(1'b0);
        tick(12);

        // three failures into lockout
        attempt(2); result(2, 1'b0, 1'b1, 1'b1);
        cmp("fail1_count", fail_count, 1);
        attempt(3); result(2, 1'b0, 1'b1, 1'b1);
        cmp("fail2_count", fail_count, 2);
        attempt(1); result(2, 1'b0, 1'b1, 1'b1);
        cmp("lock_locked_out", locked_out, 1);
        cmp("lock_buzzer", buzzer, 1);
        key(1'b0);
        submit(1'b0);
        tick(20);
        #1 cmp("post_lock_fail_count", fail_count, 0);
        cmp("post_lock_locked_out", locked_out, 0);

        // entry inactivity timeout: abandoned, later attempt_done ignored
        key(1'b1);
        tick(ETO + 4);
        submit(1'b0);
        cmp("entry_to_fail_count", fail_count, 0);

        // fail then pass
        attempt(4); result(2, 1'b0, 1'b1, 1'b1);
        attempt(4); result(3, 1'b1, 1'b0, 1'b1);
        cmp("fail_pass_count", fail_count, 0);
        tick(12);

        // response timeout counts as a failure after exactly RTO cycles
        attempt(2);
        tick(RTO);
        #1 cmp("resp_to_before_count", fail_count, 0);
        cmp("resp_to_before_busy", busy, 1);
        m_fail++;
        expect_ev(EV_FCNT, m_fail);
        tick(1);
        #1 cmp("resp_to_after_count", fail_count, 1);
        cmp("resp_to_after_busy", busy, 0);

        // simultaneous pass+fail is a failure
        attempt(3); result(2, 1'b1, 1'b1, 1'b1);
        tick(3);
        #1 cmp("both_door_open", door_open, 0);
        cmp("both_fail_count", fail_count, 2);

        // reset at cycle 5 of lockout
        attempt(2); result(2, 1'b0, 1'b1, 1'b0);
        wait_high(1'b1, "wait_lockout");
        repeat (4) @(negedge clk);
        expect_ev(EV_FCNT, 0);
        expect_ev(EV_LOCK, 5);
        #1 rst_n = 1'b0;
        #1 cmp("rst_lock_buzzer", buzzer, 0);
        cmp("rst_lock_locked_out", locked_out, 0);
        cmp("rst_lock_fail_count", fail_count, 0);
        m_fail = 0;
        tick(1); #1 rst_n = 1'b1;

        // reset at cycle 5 of open
        attempt(1); result(2, 1'b1, 1'b0, 1'b0);
        wait_high(1'b0, "wait_open");
        repeat (4) @(negedge clk);
        expect_ev(EV_OPEN, 5);
        #1 rst_n = 1'b0;
        #1 cmp("rst_open_door_open", door_open, 0);
        cmp("rst_open_buzzer", buzzer, 0);
        cmp("rst_open_fail_count", fail_count, 0);
        tick(1); #1 rst_n = 1'b1;

        // first digit after release starts an attempt
        attempt(1); result(2, 1'b0, 1'b1, 1'b1);
        tick(3);
        #1 cmp("final_fail_count", fail_count, 1);
        tick(2);
        cmp("scoreboard_drained", exp_q.size(), 0);
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
